// File: rtl/regfile_mp_clr.sv
// ---------------------------------------------------------------------------
// regfile_mp_clr
//   Multi-port register file for the CPU datapath: NUM_RD combinational read
//   ports and two write ports (A, B; B wins on an address collision).
//   A clear engine zeroes the array one entry per clock after reset or a
//   flush.  While it runs, ready is low, writes are ignored and every read
//   port returns 0.  Entry 0 can be hardwired to zero (ZERO_REG).  Same-cycle
//   write data can be forwarded to the read ports (BYPASS).
//
// Ports
//   clk    : clock, all state updates on the rising edge
//   rst    : asynchronous active-high reset, restarts the clear engine
//   flush  : synchronous request to re-clear the whole array
//   ready  : 1 = clear finished, reads and writes are valid
//   we_a, wa_a, wd_a : write port A (enable, address, data)
//   we_b, wa_b, wd_b : write port B (enable, address, data), higher priority
//   ra     : packed read addresses, port i = ra[i*ADDR_W +: ADDR_W]
//   rd     : packed read data,      port i = rd[i*DATA_W +: DATA_W]
// ---------------------------------------------------------------------------
module regfile_mp_clr #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   output logic                     ready,
   input  logic                     we_a,
   input  logic [ADDR_W-1:0]        wa_a,
   input  logic [DATA_W-1:0]        wd_a,
   input  logic                     we_b,
   input  logic [ADDR_W-1:0]        wa_b,
   input  logic [DATA_W-1:0]        wd_b,
   input  logic [NUM_RD*ADDR_W-1:0] ra,
   output logic [NUM_RD*DATA_W-1:0] rd
);

   localparam int               DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

   typedef enum logic {CLEAR, RUN} state_t;

   state_t              state_reg;
   logic [ADDR_W-1:0]   clr_cnt_reg;
   logic                ready_reg;

   logic [DATA_W-1:0]   mem [DEPTH];

   logic                wr_a;
   logic                wr_b;

   // ------------------------------------------------------------------
   // Clear engine / mode FSM.  ready is registered and tracks RUN.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= CLEAR;
         clr_cnt_reg <= '0;
         ready_reg   <= 1'b0;
      end else begin
         case (state_reg)
            CLEAR: begin
               if (flush) begin
                  clr_cnt_reg <= '0;
               end else begin
                  clr_cnt_reg <= clr_cnt_reg + 1'b1;
                  if (clr_cnt_reg == LAST) begin
                     state_reg <= RUN;
                     ready_reg <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (flush) begin
                  state_reg   <= CLEAR;
                  clr_cnt_reg <= '0;
                  ready_reg   <= 1'b0;
               end
            end
            default: begin
               state_reg   <= CLEAR;
               clr_cnt_reg <= '0;
               ready_reg   <= 1'b0;
            end
         endcase
      end
   end

   assign ready = ready_reg;

   // ------------------------------------------------------------------
   // Write qualification.  A flush edge in RUN drops the user writes, and
   // port A yields to port B when both hit the same address.
   // ------------------------------------------------------------------
   always_comb begin
      wr_a = ready_reg && !flush && we_a;
      wr_b = ready_reg && !flush && we_b;
      if (ZERO_REG != 0) begin
         if (wa_a == '0) wr_a = 1'b0;
         if (wa_b == '0) wr_b = 1'b0;
      end
      if (we_b && (wa_b == wa_a)) wr_a = 1'b0;
   end

   // Storage array: no reset, the clear engine is what initialises it.
   always_ff @(posedge clk) begin
      if (state_reg == CLEAR) begin
         mem[clr_cnt_reg] <= '0;
      end else begin
         if (wr_a) mem[wa_a] <= wd_a;
         if (wr_b) mem[wa_b] <= wd_b;
      end
   end

   // ------------------------------------------------------------------
   // Read ports: array, then A forward, then B forward (B overrides A);
   // not-ready and the hardwired zero entry force 0 last.
   // ------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
         logic [ADDR_W-1:0] addr;
         logic [DATA_W-1:0] data;

         assign addr = ra[gi*ADDR_W +: ADDR_W];

         always_comb begin
            data = mem[addr];
            if (BYPASS != 0 && !flush) begin
               if (we_a && (wa_a == addr)) data = wd_a;
               if (we_b && (wa_b == addr)) data = wd_b;
            end
            if (!ready_reg) data = '0;
            if (ZERO_REG != 0 && addr == '0) data = '0;
         end

         assign rd[gi*DATA_W +: DATA_W] = data;
      end
   endgenerate

endmodule

// File: tb/tb_regfile_mp_clr.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp_clr
//   Directed bench for regfile_mp_clr in its default configuration
//   (32x32, two read ports, hardwired zero, bypass on).
//   Inputs change 1 time unit after a rising edge; combinational outputs are
//   checked 1 time unit after that, well clear of the next edge.
// ---------------------------------------------------------------------------
module tb_regfile_mp_clr;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int NUM_RD = 2;

   logic                     clk;
   logic                     rst;
   logic                     flush;
   logic                     ready;
   logic                     we_a;
   logic [ADDR_W-1:0]        wa_a;
   logic [DATA_W-1:0]        wd_a;
   logic                     we_b;
   logic [ADDR_W-1:0]        wa_b;
   logic [DATA_W-1:0]        wd_b;
   logic [NUM_RD*ADDR_W-1:0] ra;
   logic [NUM_RD*DATA_W-1:0] rd;

   int checks = 0;
   int errors = 0;

   regfile_mp_clr #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .NUM_RD   (NUM_RD),
      .ZERO_REG (1),
      .BYPASS   (1)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .ready (ready),
      .we_a  (we_a),
      .wa_a  (wa_a),
      .wd_a  (wd_a),
      .we_b  (we_b),
      .wa_b  (wa_b),
      .wd_b  (wd_b),
      .ra    (ra),
      .rd    (rd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
      $display("check %-16s observed=0x%08h expected=0x%08h", tag, obs, exp);
   endtask

   // advance one rising edge, then move 1 unit past it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_writes();
      we_a = 1'b0; wa_a = '0; wd_a = '0;
      we_b = 1'b0; wa_b = '0; wd_b = '0;
   endtask

   initial begin
      rst   = 1'b1;
      flush = 1'b0;
      ra    = '0;
      idle_writes();

      // T1: reset held 3 cycles, then 32 clear edges
      repeat (3) step();
      ra = {5'd9, 5'd5};
      #1;
      check("rst_ready", {31'd0, ready}, 32'd0);
      check("rst_rd0", rd[31:0], 32'd0);
      check("rst_rd1", rd[63:32], 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 32; i++) begin
         #1;
         check("clr1_ready", {31'd0, ready}, 32'd0);
         check("clr1_rd0", rd[31:0], 32'd0);
         step();
      end
      #1;
      check("clr1_done", {31'd0, ready}, 32'd1);
      check("clr1_rd0_run", rd[31:0], 32'd0);
      check("clr1_rd1_run", rd[63:32], 32'd0);

      // T2: write r5 on A, read it back via bypass and then from the array
      we_a = 1'b1; wa_a = 5'd5; wd_a = 32'hDEADBEEF;
      ra = {5'd0, 5'd5};
      #1;
      check("t2_bypass", rd[31:0], 32'hDEADBEEF);
      check("t2_r0", rd[63:32], 32'd0);
      step();
      idle_writes();
      #1;
      check("t2_stored", rd[31:0], 32'hDEADBEEF);

      // T3: A and B collide on r7, B wins; also disjoint dual write
      we_a = 1'b1; wa_a = 5'd7; wd_a = 32'h1111;
      we_b = 1'b1; wa_b = 5'd7; wd_b = 32'h2222;
      ra = {5'd7, 5'd7};
      #1;
      check("t3_bypass0", rd[31:0], 32'h2222);
      check("t3_bypass1", rd[63:32], 32'h2222);
      step();
      we_a = 1'b1; wa_a = 5'd9;  wd_a = 32'hAAAA;
      we_b = 1'b1; wa_b = 5'd10; wd_b = 32'hBBBB;
      ra = {5'd7, 5'd7};
      #1;
      check("t3_stored", rd[31:0], 32'h2222);
      step();
      idle_writes();
      ra = {5'd10, 5'd9};
      #1;
      check("t3_dual_a", rd[31:0], 32'hAAAA);
      check("t3_dual_b", rd[63:32], 32'hBBBB);

      // T4: writes to r0 on both ports are dropped
      we_a = 1'b1; wa_a = 5'd0; wd_a = 32'hFFFFFFFF;
      we_b = 1'b1; wa_b = 5'd0; wd_b = 32'hFFFFFFFF;
      ra = {5'd5, 5'd0};
      #1;
      check("t4_r0_same", rd[31:0], 32'd0);
      check("t4_r5", rd[63:32], 32'hDEADBEEF);
      step();
      idle_writes();
      #1;
      check("t4_r0_later", rd[31:0], 32'd0);

      // T5: r3=0x55, flush, write during clear is lost
      we_a = 1'b1; wa_a = 5'd3; wd_a = 32'h55;
      step();
      idle_writes();
      ra = {5'd5, 5'd3};
      #1;
      check("t5_r3_pre", rd[31:0], 32'h55);
      flush = 1'b1;
      we_a = 1'b1; wa_a = 5'd3; wd_a = 32'h77;   // dropped by the flush edge
      step();
      flush = 1'b0;
      idle_writes();
      for (int i = 0; i < 32; i++) begin
         #1;
         check("clr2_ready", {31'd0, ready}, 32'd0);
         if (i == 5) begin
            we_a = 1'b1; wa_a = 5'd3; wd_a = 32'h99;
         end else begin
            we_a = 1'b0;
         end
         step();
      end
      idle_writes();
      #1;
      check("clr2_done", {31'd0, ready}, 32'd1);
      check("t5_r3_cleared", rd[31:0], 32'd0);
      check("t5_r5_cleared", rd[63:32], 32'd0);

      // T6: async reset from RUN, then reset again at clear edge 10
      we_a = 1'b1; wa_a = 5'd12; wd_a = 32'h1234;
      step();
      idle_writes();
      ra = {5'd3, 5'd12};
      #1;
      check("t6_r12_pre", rd[31:0], 32'h1234);
      rst = 1'b1;
      #1;
      check("t6_async_ready", {31'd0, ready}, 32'd0);
      check("t6_async_rd", rd[31:0], 32'd0);
      step();
      rst = 1'b0;
      repeat (10) step();
      #1;
      check("t6_mid_ready", {31'd0, ready}, 32'd0);
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      for (int i = 0; i < 32; i++) begin
         #1;
         check("clr3_ready", {31'd0, ready}, 32'd0);
         step();
      end
      #1;
      check("clr3_done", {31'd0, ready}, 32'd1);
      check("t6_r12_cleared", rd[31:0], 32'd0);
      check("t6_r3_cleared", rd[63:32], 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
